// File: rtl/regression_job_scheduler.sv
// Regression job scheduler: shares one Regression engine among N_REQ requesters.
// Round-robin grant, one eng_start pulse, then tracking of eng_ready through
// ack (ready low) and completion (ready high). The engine results are captured
// and returned to the granted requester with a one-cycle done pulse.
// Optional build macro: REG_SCHED_TIMEOUT_EN adds a per-job wait timeout.
// When it is defined, a job aborts after TIMEOUT wait cycles in WAIT_ACK/WAIT_DONE.
// That abort returns zero results and raises timeout_err together with done.
module regression_job_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = 20,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [N_REQ-1:0]                req_i,
    output logic [N_REQ-1:0]                gnt_o,
    output logic [N_REQ-1:0]                done_o,
    output logic [DW-1:0]                   res_b1_o,
    output logic [DW-1:0]                   res_b0_o,
    output logic [$clog2(N_REQ)-1:0]        res_id_o,
    output logic                            busy_o,
    output logic                            timeout_err_o,
    output logic                            eng_start_o,
    input  logic                            eng_ready_i,
    input  logic [DW-1:0]                   eng_b_1_i,
    input  logic [DW-1:0]                   eng_b_0_i
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned PW  = IDW + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CAPTURE   = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [DW-1:0]    res_b1_q, res_b1_d;
    logic [DW-1:0]    res_b0_q, res_b0_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             busy_q, busy_d;
    logic             eng_start_q, eng_start_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [PW-1:0]    cand;

`ifdef REG_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    // Round-robin search: first requester after rr_ptr_q, wrapping back to rr_ptr_q itself
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = PW'({1'b0, rr_ptr_q}) + PW'(i);
            if (cand >= PW'(N_REQ)) begin
                cand = cand - PW'(N_REQ);
            end
            if (!win_found && req_i[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    // Next-state and registered-output decode for the job sequencer
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        res_b1_d    = res_b1_q;
        res_b0_d    = res_b0_q;
        res_id_d    = res_id_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        eng_start_d = 1'b0;
`ifdef REG_SCHED_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (win_found && eng_ready_i) begin
                    gnt_d   = N_REQ'(1) << win_idx;
                    id_d    = win_idx;
                    state_d = S_START;
                end
            end
            S_START: begin
                eng_start_d = 1'b1;
                state_d     = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!eng_ready_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (eng_ready_i) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                res_b1_d = eng_b_1_i;
                res_b0_d = eng_b_0_i;
                res_id_d = id_q;
                done_d   = N_REQ'(1) << id_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                gnt_d    = '0;
                rr_ptr_d = id_q;
                state_d  = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

`ifdef REG_SCHED_TIMEOUT_EN
        // Abort once TIMEOUT wait cycles have elapsed; overrides any engine progress that cycle
        if (state_q == S_START) begin
            tmo_cnt_d = '0;
        end else if ((state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE)) begin
            if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
                res_b1_d      = '0;
                res_b0_d      = '0;
                res_id_d      = id_q;
                done_d        = N_REQ'(1) << id_q;
                timeout_err_d = 1'b1;
                state_d       = S_DONE;
            end else begin
                tmo_cnt_d = CW'(tmo_cnt_q + CW'(1));
            end
        end
`endif

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            res_b1_q    <= '0;
            res_b0_q    <= '0;
            res_id_q    <= '0;
            id_q        <= '0;
            rr_ptr_q    <= IDW'(N_REQ - 1);
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            res_b1_q    <= res_b1_d;
            res_b0_q    <= res_b0_d;
            res_id_q    <= res_id_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
        end
    end

`ifdef REG_SCHED_TIMEOUT_EN
    // Timeout counter and error flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign res_b1_o    = res_b1_q;
    assign res_b0_o    = res_b0_q;
    assign res_id_o    = res_id_q;
    assign busy_o      = busy_q;
    assign eng_start_o = eng_start_q;

endmodule

// File: tb/tb_regression_job_scheduler.sv
// Bench for regression_job_scheduler: engine model, job-level reference model,
// per-cycle output compare plus directed scenarios and a randomized phase.
module tb_regression_job_scheduler;

    localparam int N   = 4;
    localparam int DW  = 20;
    localparam int TMO = 16;

    logic          clk;
    logic          rst_ni;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt_o, done_o;
    logic [DW-1:0] res_b1_o, res_b0_o;
    logic [1:0]    res_id_o;
    logic          busy_o, terr_o, eng_start_o;
    logic          eng_ready;
    logic [DW-1:0] eng_b1, eng_b0;

    int checks   = 0;
    int failures = 0;

    regression_job_scheduler #(.N_REQ(N), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .res_b1_o     (res_b1_o),
        .res_b0_o     (res_b0_o),
        .res_id_o     (res_id_o),
        .busy_o       (busy_o),
        .timeout_err_o(terr_o),
        .eng_start_o  (eng_start_o),
        .eng_ready_i  (eng_ready),
        .eng_b_1_i    (eng_b1),
        .eng_b_0_i    (eng_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- engine model ----------------
    int   cfg_ack   = -1;   // cycles from start to ready low (-1: random)
    int   cfg_busy  = -1;   // cycles ready stays low (-1: random)
    logic cfg_fixb  = 1'b0;
    logic eng_hang  = 1'b0;

    task automatic run_engine();
        int a, b;
        a = (cfg_ack  < 0) ? int'($urandom_range(0, 3)) : cfg_ack;
        b = (cfg_busy < 0) ? int'($urandom_range(1, 8)) : cfg_busy;
        repeat (a) begin @(posedge clk); #1; end
        eng_ready = 1'b0;
        while (eng_hang) begin @(posedge clk); #1; end
        repeat (b) begin @(posedge clk); #1; end
        if (cfg_fixb) begin
            eng_b1 = 20'h00003;
            eng_b0 = 20'h00001;
        end else begin
            eng_b1 = DW'($urandom);
            eng_b0 = DW'($urandom);
        end
        eng_ready = 1'b1;
    endtask

    always begin
        @(posedge clk); #1;
        if (rst_ni && eng_start_o === 1'b1) run_engine();
    end

    // ---------------- reference model ----------------
    logic [N-1:0]  e_gnt, e_done;
    logic [DW-1:0] e_b1, e_b0;
    logic [1:0]    e_id;
    logic          e_busy, e_start, e_terr;
    int m_active, m_owner, m_t, m_wait, m_last;
    bit m_ack, m_cap, m_fin, timed;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            e_gnt = '0; e_done = '0; e_b1 = '0; e_b0 = '0; e_id = '0;
            e_busy = 0; e_start = 0; e_terr = 0;
            m_active = 0; m_owner = 0; m_t = 0; m_wait = 0; m_last = N - 1;
            m_ack = 0; m_cap = 0; m_fin = 0;
        end else begin
            e_done = '0; e_terr = 0; e_start = 0;
            if (m_active != 0) begin
                m_t++;
                if (m_fin) begin
                    m_active = 0; m_last = m_owner; e_gnt = '0; e_busy = 0; m_fin = 0;
                end else if (m_cap) begin
                    e_b1 = eng_b1; e_b0 = eng_b0; e_id = 2'(m_owner);
                    e_done = '0; e_done[m_owner] = 1'b1; m_fin = 1; m_cap = 0;
                end else if (m_t == 1) begin
                    e_start = 1;
                end else begin
                    m_wait++;
                    timed = 0;
`ifdef REG_SCHED_TIMEOUT_EN
                    timed = (m_wait == TMO);
`endif
                    if (timed) begin
                        e_b1 = '0; e_b0 = '0; e_id = 2'(m_owner);
                        e_done = '0; e_done[m_owner] = 1'b1; e_terr = 1; m_fin = 1;
                    end else if (!m_ack) begin
                        if (!eng_ready) m_ack = 1;
                    end else if (eng_ready) begin
                        m_cap = 1;
                    end
                end
            end else if (req != 0 && eng_ready) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_active == 0 && req[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_active = 1;
                    end
                end
                m_t = 0; m_wait = 0; m_ack = 0; m_cap = 0; m_fin = 0;
                e_gnt = '0; e_gnt[m_owner] = 1'b1; e_busy = 1;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_ni) begin
            chk("gnt",       gnt_o,       e_gnt);
            chk("done",      done_o,      e_done);
            chk("busy",      busy_o,      e_busy);
            chk("eng_start", eng_start_o, e_start);
            chk("res_b1",    res_b1_o,    e_b1);
            chk("res_b0",    res_b0_o,    e_b0);
            chk("res_id",    res_id_o,    e_id);
            chk("terr",      terr_o,      e_terr);
            chk("gnt_onehot", ($countones(gnt_o) <= 1), 1);
        end
    end

    int start_cnt = 0;
    always @(negedge clk) if (eng_start_o === 1'b1) start_cnt++;

    // ---------------- helpers ----------------
    task automatic wait_gnt(input string nm, input int lim);
        int n = 0;
        while (gnt_o == '0 && n < lim) begin @(negedge clk); n++; end
        if (gnt_o == '0) chk({nm, "_gnt_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string nm, input int lim);
        int n = 0;
        while (done_o == '0 && n < lim) begin @(negedge clk); n++; end
        if (done_o == '0) chk({nm, "_done_timeout"}, 0, 1);
    endtask

    task automatic wait_engine_idle();
        int n = 0;
        while ((!eng_ready || busy_o) && n < 200) begin @(negedge clk); n++; end
        if (!eng_ready || busy_o) chk("engine_idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        oh2i = -1;
        for (int k = 0; k < N; k++) if (v[k]) oh2i = k;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random stimulus ----------------
    initial begin
        int order[$];
        int gap, s0, n, dc, gc;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst_ni = 1'b0; req = '0; eng_ready = 1'b1; eng_b1 = '0; eng_b0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt",  gnt_o,  0);
        chk("rst_busy", busy_o, 0);
        chk("rst_res",  {12'h0, res_b1_o} | {12'h0, res_b0_o} | {30'h0, res_id_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Single job with fixed engine timing and results
        cfg_ack = 1; cfg_busy = 10; cfg_fixb = 1'b1;
        s0 = start_cnt;
        req = 4'b0001;
        @(negedge clk);
        chk("t1_gnt", gnt_o, 4'b0001);
        wait_done("t1", 60);
        chk("t1_done", done_o, 4'b0001);
        chk("t1_b1", res_b1_o, 20'h00003);
        chk("t1_b0", res_b0_o, 20'h00001);
        chk("t1_id", res_id_o, 0);
        chk("t1_starts", start_cnt - s0, 1);
        req = '0;
        wait_engine_idle();

        // All requesting: round-robin order and one idle cycle between jobs
        do_reset();
        cfg_busy = 3; cfg_fixb = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("t2", 60);
            order.push_back(oh2i(gnt_o));
            wait_done("t2", 60);
            if (k < 4) begin
                gap = 0;
                @(negedge clk);
                while (!busy_o && gap < 20) begin gap++; @(negedge clk); end
                chk("t2_gap", gap, 1);
            end
        end
        for (int k = 0; k < 5; k++) chk("t2_order", order[k], exp_order[k]);
        req = '0;
        wait_engine_idle();

        // Requester drops its request mid-job
        do_reset();
        req = 4'b0100;
        wait_gnt("t3", 20);
        repeat (2) @(negedge clk);
        req = '0;
        wait_done("t3", 60);
        chk("t3_done", done_o, 4'b0100);
        gc = 0;
        repeat (6) begin @(negedge clk); if (gnt_o != 0) gc++; end
        chk("t3_no_regrant", gc, 0);
        wait_engine_idle();

        // Reset during WAIT_DONE
        cfg_busy = 10;
        req = 4'b0001;
        wait_gnt("t4", 20);
        n = 0;
        while (eng_ready && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("t4_rst_outs", {gnt_o, done_o, busy_o, eng_start_o, terr_o, res_id_o}, 0);
        chk("t4_rst_res", {12'h0, res_b1_o} | {12'h0, res_b0_o}, 0);
        @(negedge clk);
        req = '0;
        rst_ni = 1'b1;
        wait_engine_idle();
        req = 4'b1010;
        @(negedge clk);
        chk("t4_gnt", gnt_o, 4'b0010);
        wait_done("t4", 60);
        req = '0;
        wait_engine_idle();

        // Engine never finishes
        do_reset();
        eng_hang = 1'b1;
        req = 4'b0001;
        n = 0;
        while (!eng_start_o && n < 20) begin @(negedge clk); n++; end
`ifdef REG_SCHED_TIMEOUT_EN
        n = 0;
        while (done_o == 0 && n < 60) begin @(negedge clk); n++; end
        chk("t5_tmo_cycles", n, TMO);
        chk("t5_done", done_o, 4'b0001);
        chk("t5_terr", terr_o, 1);
        chk("t5_res", {12'h0, res_b1_o} | {12'h0, res_b0_o}, 0);
`else
        dc = 0;
        repeat (40) begin @(negedge clk); if (done_o != 0) dc++; end
        chk("t5_busy_held", busy_o, 1);
        chk("t5_no_done", dc, 0);
`endif
        req = '0;
        eng_hang = 1'b0;
        wait_engine_idle();
        do_reset();

        // Engine not ready while idle
        req = 4'b0001;
        eng_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_gnt", gnt_o, 0);
        eng_ready = 1'b1;
        @(negedge clk);
        chk("t6_gnt", gnt_o, 4'b0001);
        wait_done("t6", 60);
        req = '0;
        wait_engine_idle();

        // Randomized traffic against the model
        cfg_ack = -1; cfg_busy = -1;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 4) == 0) req = N'($urandom);
        end
        req = '0;
        wait_engine_idle();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
